// File: rtl/gj_elim_sequencer.sv
// Gauss-Jordan elimination sequencer for an N x 2N augmented matrix [A | I] in an external RAM.
// Produces [D | D*A^-1] using division-free cross-multiply row updates and flags a singular A.
module gj_elim_sequencer #(
  parameter int N  = 5,
  parameter int W  = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          singular,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [W-1:0]  mem_rdata,
  output logic          mem_wr_en,
  output logic [W-1:0]  mem_wdata
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(2 * N);

  typedef enum logic [3:0] {
    IDLE, PS_RD, PS_CHK, SW_RDK, SW_RDR, SW_WRK, SW_WRR,
    EL_FRD, EL_FCHK, EL_RDP, EL_RDX, EL_WR, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] k_q, k_d, r_q, r_d, i_q, i_d;
  logic [CW-1:0] j_q, j_d;
  logic [W-1:0]  p_q, p_d, f_q, f_d, pr_q, pr_d, tmp_q, tmp_d;
  logic          busy_q, busy_d, done_q, done_d, sing_q, sing_d;
  logic          rd_q, rd_d, wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rowDone, startElim;
  int            nextI;

  function automatic logic [AW-1:0] cellAddr(input int row, input int col);
    return AW'(row * 2 * N + col);
  endfunction

  // Next row to eliminate after 'row', stepping over the pivot row itself.
  function automatic int nextRow(input int row, input int piv);
    int n;
    n = row + 1;
    if (n == piv) n = n + 1;
    return n;
  endfunction

  // Strobes and addresses are set on the edge entering the state that owns them,
  // so read data for a request issued in one state is consumed in the next.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    r_d       = r_q;
    i_d       = i_q;
    j_d       = j_q;
    p_d       = p_q;
    f_d       = f_q;
    pr_d      = pr_q;
    tmp_d     = tmp_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sing_d    = sing_q;
    addr_d    = addr_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    rowDone   = 1'b0;
    startElim = 1'b0;
    nextI     = 0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PS_RD;
          k_d     = '0;
          r_d     = '0;
          busy_d  = 1'b1;
          sing_d  = 1'b0;
          rd_d    = 1'b1;
          addr_d  = cellAddr(0, 0);
        end
      end
      PS_RD: state_d = PS_CHK;
      PS_CHK: begin
        if (mem_rdata != '0) begin
          p_d = mem_rdata;
          if (r_q == k_q) begin
            startElim = 1'b1;
          end else begin
            j_d     = '0;
            state_d = SW_RDK;
            rd_d    = 1'b1;
            addr_d  = cellAddr(int'(k_q), 0);
          end
        end else if (int'(r_q) < N - 1) begin
          r_d     = r_q + 1'b1;
          state_d = PS_RD;
          rd_d    = 1'b1;
          addr_d  = cellAddr(int'(r_q) + 1, int'(k_q));
        end else begin
          sing_d  = 1'b1;
          state_d = DONE;
        end
      end
      SW_RDK: begin
        state_d = SW_RDR;
        rd_d    = 1'b1;
        addr_d  = cellAddr(int'(r_q), int'(j_q));
      end
      SW_RDR: begin
        tmp_d   = mem_rdata;
        state_d = SW_WRK;
        wr_d    = 1'b1;
        addr_d  = cellAddr(int'(k_q), int'(j_q));
      end
      SW_WRK: begin
        state_d = SW_WRR;
        wr_d    = 1'b1;
        addr_d  = cellAddr(int'(r_q), int'(j_q));
      end
      SW_WRR: begin
        if (int'(j_q) < 2 * N - 1) begin
          j_d     = j_q + 1'b1;
          state_d = SW_RDK;
          rd_d    = 1'b1;
          addr_d  = cellAddr(int'(k_q), int'(j_q) + 1);
        end else begin
          startElim = 1'b1;
        end
      end
      EL_FRD: state_d = EL_FCHK;
      EL_FCHK: begin
        if (mem_rdata == '0) begin
          rowDone = 1'b1;
        end else begin
          f_d     = mem_rdata;
          j_d     = '0;
          state_d = EL_RDP;
          rd_d    = 1'b1;
          addr_d  = cellAddr(int'(k_q), 0);
        end
      end
      EL_RDP: begin
        state_d = EL_RDX;
        rd_d    = 1'b1;
        addr_d  = cellAddr(int'(i_q), int'(j_q));
      end
      EL_RDX: begin
        pr_d    = mem_rdata;
        state_d = EL_WR;
        wr_d    = 1'b1;
        addr_d  = cellAddr(int'(i_q), int'(j_q));
      end
      EL_WR: begin
        if (int'(j_q) < 2 * N - 1) begin
          j_d     = j_q + 1'b1;
          state_d = EL_RDP;
          rd_d    = 1'b1;
          addr_d  = cellAddr(int'(k_q), int'(j_q) + 1);
        end else begin
          rowDone = 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Shared row/column advance: next target row, else next pivot column, else finish.
    if (startElim) begin
      nextI = nextRow(-1, int'(k_q));
    end else if (rowDone) begin
      nextI = nextRow(int'(i_q), int'(k_q));
    end
    if (startElim || rowDone) begin
      if (nextI < N) begin
        i_d     = RW'(nextI);
        state_d = EL_FRD;
        rd_d    = 1'b1;
        addr_d  = cellAddr(nextI, int'(k_q));
      end else if (int'(k_q) < N - 1) begin
        k_d     = k_q + 1'b1;
        r_d     = k_q + 1'b1;
        state_d = PS_RD;
        rd_d    = 1'b1;
        addr_d  = cellAddr(int'(k_q) + 1, int'(k_q) + 1);
      end else begin
        state_d = DONE;
      end
    end
  end

  // Write data is formed from the word arriving this cycle, so writes need no extra cycle.
  always_comb begin
    mem_wdata = '0;
    case (state_q)
      SW_WRK:  mem_wdata = mem_rdata;
      SW_WRR:  mem_wdata = tmp_q;
      EL_WR:   mem_wdata = p_q * mem_rdata - f_q * pr_q;
      default: mem_wdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      r_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      p_q     <= '0;
      f_q     <= '0;
      pr_q    <= '0;
      tmp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sing_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      r_q     <= r_d;
      i_q     <= i_d;
      j_q     <= j_d;
      p_q     <= p_d;
      f_q     <= f_d;
      pr_q    <= pr_d;
      tmp_q   <= tmp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sing_q  <= sing_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign singular  = sing_q;
  assign mem_addr  = addr_q;
  assign mem_rd_en = rd_q;
  assign mem_wr_en = wr_q;

endmodule

// File: tb/tb_gj_elim_sequencer.sv
// Bench for gj_elim_sequencer: table vectors, random matrices against a software
// Gauss-Jordan model, plus start-while-busy and mid-run reset sequences.
`timescale 1ns/1ps
module tb_gj_elim_sequencer;
  localparam int N  = 5;
  localparam int W  = 32;
  localparam int AW = 6;
  localparam int RC = 2 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, singular, mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_rdata, mem_wdata;

  logic [W-1:0]  ram [64];
  logic          loadEn = 1'b0;
  logic [AW-1:0] loadAddr = '0;
  logic [W-1:0]  loadData = '0;
  int            wrCount = 0, doneCount = 0, bothHigh = 0;
  int            checks = 0, passes = 0;
  logic [W-1:0]  refM [N][RC];
  int            aMat [N][N];

  typedef struct {
    int kind;
    bit expSing;
    int expCycles;
    int expWrites;
  } vec_t;
  vec_t vecs [4];

  gj_elim_sequencer #(.N(N), .W(W), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .singular(singular), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle read latency; the load port is only used while the DUT idles.
  always @(posedge clk) begin
    if (loadEn) ram[loadAddr] <= loadData;
    else if (mem_wr_en) ram[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_wr_en) wrCount <= wrCount + 1;
    if (done) doneCount <= doneCount + 1;
    if (mem_wr_en && mem_rd_en) bothHigh <= bothHigh + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic makeMatrix(input int kind);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        aMat[r][c] = (r == c) ? 1 : 0;
    case (kind)
      1: for (int r = 0; r < N; r++)
           for (int c = 0; c < N; c++)
             aMat[r][c] = (c == 0) ? 0 : int'($urandom_range(0, 6)) - 3;
      2: begin aMat[0][0] = 0; aMat[0][1] = 2; aMat[1][0] = 3; aMat[1][1] = 0; end
      3: begin aMat[0][0] = 2; aMat[0][1] = 1; aMat[1][0] = 1; aMat[1][1] = 1; end
      4: for (int r = 0; r < N; r++)
           for (int c = 0; c < N; c++)
             aMat[r][c] = int'($urandom_range(0, 6)) - 3;
      default: ;
    endcase
  endtask

  function automatic logic [W-1:0] cellValue(input int r, input int c);
    if (c < N) return W'(aMat[r][c]);
    return (c - N == r) ? 32'd1 : 32'd0;
  endfunction

  task automatic buildRef();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < RC; c++)
        refM[r][c] = cellValue(r, c);
  endtask

  task automatic loadRam();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < RC; c++) begin
        @(negedge clk);
        loadEn = 1'b1;
        loadAddr = AW'(r * RC + c);
        loadData = cellValue(r, c);
      end
    @(negedge clk);
    loadEn = 1'b0;
  endtask

  // Whole-matrix elimination in plain arithmetic, with cycle and write costs tallied per step.
  task automatic runModel(output bit sing, output int cyc, output int wr);
    logic [W-1:0] p, f, t;
    int piv;
    sing = 1'b0;
    cyc = 1;
    wr = 0;
    for (int k = 0; k < N && !sing; k++) begin
      piv = -1;
      for (int r = k; r < N; r++)
        if (piv < 0) begin
          cyc += 2;
          if (refM[r][k] != 0) piv = r;
        end
      if (piv < 0) begin
        sing = 1'b1;
      end else begin
        if (piv != k) begin
          for (int j = 0; j < RC; j++) begin
            t = refM[k][j];
            refM[k][j] = refM[piv][j];
            refM[piv][j] = t;
          end
          cyc += 4 * RC;
          wr += 2 * RC;
        end
        p = refM[k][k];
        for (int i = 0; i < N; i++)
          if (i != k) begin
            cyc += 2;
            f = refM[i][k];
            if (f != 0) begin
              for (int j = 0; j < RC; j++)
                refM[i][j] = p * refM[i][j] - f * refM[k][j];
              cyc += 3 * RC;
              wr += RC;
            end
          end
      end
    end
  endtask

  task automatic applyStimulus(input string tag, output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput({tag, ".doneSeen"}, 32'(done), 32'd1);
  endtask

  task automatic compareRam(input string tag);
    int mism;
    mism = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < RC; c++)
        if (ram[r * RC + c] !== refM[r][c]) mism++;
    checkOutput({tag, ".ram"}, mism, 0);
  endtask

  task automatic runCase(input string tag, input bit eSing, input int eCyc, input int eWr);
    int cyc, w0, b0;
    loadRam();
    w0 = wrCount;
    b0 = bothHigh;
    applyStimulus(tag, cyc);
    checkOutput({tag, ".singular"}, 32'(singular), 32'(eSing));
    checkOutput({tag, ".latency"}, cyc, eCyc);
    checkOutput({tag, ".writes"}, wrCount - w0, eWr);
    checkOutput({tag, ".strobes"}, bothHigh - b0, 0);
    checkOutput({tag, ".busyLow"}, 32'(busy), 0);
    compareRam(tag);
  endtask

  initial begin
    bit mS;
    int mC, mW, tries, n, d0, w0, cyc;

    vecs[0] = '{kind: 0, expSing: 1'b0, expCycles: 51,  expWrites: 0};
    vecs[1] = '{kind: 1, expSing: 1'b1, expCycles: 11,  expWrites: 0};
    vecs[2] = '{kind: 2, expSing: 1'b0, expCycles: 93,  expWrites: 20};
    vecs[3] = '{kind: 3, expSing: 1'b0, expCycles: 111, expWrites: 20};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.ctl", {27'd0, busy, done, singular, mem_rd_en, mem_wr_en}, 0);
    checkOutput("reset.addr", 32'(mem_addr), 0);
    checkOutput("reset.wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      makeMatrix(vecs[v].kind);
      buildRef();
      runModel(mS, mC, mW);
      runCase($sformatf("vec%0d", v), vecs[v].expSing, vecs[v].expCycles, vecs[v].expWrites);
    end

    for (int t = 0; t < 3; t++) begin
      tries = 0;
      do begin
        makeMatrix(4);
        buildRef();
        runModel(mS, mC, mW);
        tries++;
      end while (mS && tries < 20);
      runCase($sformatf("rand%0d", t), mS, mC, mW);
    end

    // Start pulsed again mid-run must be ignored and yield a single done pulse.
    makeMatrix(3);
    buildRef();
    runModel(mS, mC, mW);
    loadRam();
    d0 = doneCount;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busy.afterStart", 32'(busy), 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("busy.doneSeen", 32'(done), 1);
    repeat (150) @(posedge clk);
    #1;
    checkOutput("busy.donePulses", doneCount - d0, 1);
    checkOutput("busy.idle", 32'(busy), 0);
    compareRam("busy");

    // Reset dropped during the first elimination write.
    loadRam();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (mem_wr_en !== 1'b1 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("rst.wrSeen", 32'(mem_wr_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst.ctl", {27'd0, busy, done, singular, mem_rd_en, mem_wr_en}, 0);
    checkOutput("rst.addr", 32'(mem_addr), 0);
    checkOutput("rst.wdata", mem_wdata, 0);
    w0 = wrCount;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.noWrites", wrCount - w0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    buildRef();
    runModel(mS, mC, mW);
    runCase("rerun", mS, mC, mW);

    cyc = checks;
    $display("[TB] %0d/%0d checks passed", passes, cyc);
    $finish;
  end

endmodule
